// File: rtl/keyboard_cmd_queue_pkg.sv
// Shared definitions for the keyboard command queue: direction codes, ASCII
// constants, parser state encoding and the plain-key decode helper.
package kbd_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] ASCII_ESC  = 8'h1B;
  localparam logic [7:0] ASCII_LBRK = 8'h5B;
  localparam logic [7:0] ASCII_W_UC = 8'h57;
  localparam logic [7:0] ASCII_W_LC = 8'h77;
  localparam logic [7:0] ASCII_S_UC = 8'h53;
  localparam logic [7:0] ASCII_S_LC = 8'h73;
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_D_UC = 8'h44;
  localparam logic [7:0] ASCII_D_LC = 8'h64;
  localparam logic [7:0] ASCII_P_UC = 8'h50;
  localparam logic [7:0] ASCII_P_LC = 8'h70;
  localparam logic [7:0] ASCII_B_UC = 8'h42;
  localparam logic [7:0] ASCII_C_UC = 8'h43;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2
  } parser_state_t;

  typedef struct packed {
    logic       push;
    logic [1:0] dir;
    logic       pause;
    logic       esc;
  } key_decode_t;

  // Decode of a byte seen while the parser is idle (also reused when ESC is
  // followed by anything other than '[').
  function automatic key_decode_t decode_plain(input logic [7:0] b);
    key_decode_t r;
    r = '0;
    case (b)
      ASCII_W_UC, ASCII_W_LC: begin r.push = 1'b1; r.dir = DIR_UP;    end
      ASCII_S_UC, ASCII_S_LC: begin r.push = 1'b1; r.dir = DIR_DOWN;  end
      ASCII_A_UC, ASCII_A_LC: begin r.push = 1'b1; r.dir = DIR_LEFT;  end
      ASCII_D_UC, ASCII_D_LC: begin r.push = 1'b1; r.dir = DIR_RIGHT; end
      ASCII_P_UC, ASCII_P_LC: r.pause = 1'b1;
      ASCII_ESC:              r.esc = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  // Held levels ordered {up, down, left, right}.
  function automatic logic [3:0] dir_to_held(input logic [1:0] dir);
    case (dir)
      DIR_UP:   return 4'b1000;
      DIR_DOWN: return 4'b0100;
      DIR_LEFT: return 4'b0010;
      default:  return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/keyboard_cmd_queue_if.sv
// Byte-in / command-out bus of the keyboard command queue.
// Handshakes: a byte is taken on every cycle uart_valid is high (no back-pressure);
// a command is popped on every cycle where cmd_valid && cmd_ready are both high.
interface keyboard_cmd_queue_if;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;

  modport master (
    output uart_data, uart_valid, cmd_ready,
    input  cmd_valid, cmd_dir
  );

  modport slave (
    input  uart_data, uart_valid, cmd_ready,
    output cmd_valid, cmd_dir
  );
endinterface

// File: rtl/keyboard_cmd_queue_cmd_fifo.sv
// DEPTH x 2-bit synchronous FIFO, first-word-fall-through, pointers carry an
// extra wrap bit. A write while full is dropped unless a read happens that cycle.
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_dir,
  input  logic       rd_en,
  output logic [1:0] rd_dir,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_dir  = empty ? 2'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dir;
  end

endmodule

// File: rtl/keyboard_cmd_queue.sv
// UART byte parser (WASD, ANSI arrows, pause) feeding a direction FIFO, with
// stretched one-hot "held" levels and an overflow pulse for dropped commands.
module keyboard_cmd_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1000000,
  parameter int ESC_TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keyboard_cmd_queue_if.slave  bus,
  output logic                 held_up,
  output logic                 held_down,
  output logic                 held_left,
  output logic                 held_right,
  output logic                 pause_pulse,
  output logic                 overflow,
  output parser_state_t        dbg_state
);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int EW = (ESC_TIMEOUT > 0) ? $clog2(ESC_TIMEOUT + 1) : 1;

  parser_state_t state;
  parser_state_t next_state;
  logic [EW-1:0] esc_cnt;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    held;
  logic          push;
  logic [1:0]    push_dir;
  logic          pause_hit;
  logic          load_timer;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  key_decode_t   dec;

  assign dec       = decode_plain(bus.uart_data);
  assign pop       = bus.cmd_valid && bus.cmd_ready;
  assign dbg_state = state;
  assign {held_up, held_down, held_left, held_right} = held;

  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_dir   = DIR_UP;
    pause_hit  = 1'b0;
    load_timer = 1'b0;
    if (bus.uart_valid) begin
      case (state)
        ST_CSI: begin
          next_state = ST_IDLE;
          case (bus.uart_data)
            ASCII_A_UC: begin push = 1'b1; push_dir = DIR_UP;    end
            ASCII_B_UC: begin push = 1'b1; push_dir = DIR_DOWN;  end
            ASCII_C_UC: begin push = 1'b1; push_dir = DIR_RIGHT; end
            ASCII_D_UC: begin push = 1'b1; push_dir = DIR_LEFT;  end
            default: ;
          endcase
        end
        default: begin
          // ESC followed by a non-'[' byte falls back to a plain decode of that byte.
          if (state == ST_ESC && bus.uart_data == ASCII_LBRK) begin
            next_state = ST_CSI;
            load_timer = 1'b1;
          end else begin
            push       = dec.push;
            push_dir   = dec.dir;
            pause_hit  = dec.pause;
            next_state = dec.esc ? ST_ESC : ST_IDLE;
            load_timer = dec.esc;
          end
        end
      endcase
    end else if (state != ST_IDLE && esc_cnt == '0) begin
      next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      esc_cnt     <= '0;
      pause_pulse <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= next_state;
      pause_pulse <= pause_hit;
      overflow    <= push && fifo_full && !pop;
      if (load_timer)
        esc_cnt <= EW'(ESC_TIMEOUT);
      else if (state != ST_IDLE && esc_cnt != '0)
        esc_cnt <= esc_cnt - EW'(1);
    end
  end

  // Held levels stay up through hold_cnt reaching 1, so HOLD_CYCLES=0 still
  // yields a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held     <= '0;
      hold_cnt <= '0;
    end else if (push) begin
      held     <= dir_to_held(push_dir);
      hold_cnt <= HW'(HOLD_CYCLES);
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
      if (hold_cnt <= HW'(1)) held <= '0;
    end
  end

  cmd_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_dir (push_dir),
    .rd_en  (bus.cmd_ready),
    .rd_dir (bus.cmd_dir),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign bus.cmd_valid = !fifo_empty;

endmodule

// File: tb/tb_keyboard_cmd_queue.sv
// Directed bench for keyboard_cmd_queue: WASD, arrows, escape timeout, FIFO
// overflow, hold stretching, pause pulse and mid-sequence reset.
module tb_keyboard_cmd_queue;
  import kbd_pkg::*;

  localparam int DEPTH       = 4;
  localparam int HOLD_CYCLES = 10;
  localparam int ESC_TIMEOUT = 20;

  logic          clk;
  logic          rst_n;
  logic          held_up, held_down, held_left, held_right;
  logic          pause_pulse;
  logic          overflow;
  parser_state_t dbg_state;

  int n_checks;
  int n_pass;
  logic [1:0] exp_q[$];

  keyboard_cmd_queue_if bus ();

  keyboard_cmd_queue #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .ESC_TIMEOUT (ESC_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .held_up     (held_up),
    .held_down   (held_down),
    .held_left   (held_left),
    .held_right  (held_right),
    .pause_pulse (pause_pulse),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] held_vec();
    return {held_up, held_down, held_left, held_right};
  endfunction

  // drivers: inputs change on negedge, outputs sampled on negedge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.uart_data  = b;
    bus.uart_valid = 1'b1;
    @(negedge clk);
    bus.uart_valid = 1'b0;
  endtask

  task automatic send_pop(input logic [7:0] b);
    @(negedge clk);
    bus.uart_data  = b;
    bus.uart_valid = 1'b1;
    bus.cmd_ready  = 1'b1;
    @(negedge clk);
    bus.uart_valid = 1'b0;
    bus.cmd_ready  = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
  endtask

  task automatic drain_expected(input string tag);
    logic [1:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(bus.cmd_valid), 32'd1);
      check({tag, "_dir"}, 32'(bus.cmd_dir), 32'(e));
      pop_one();
    end
    check({tag, "_empty"}, 32'(bus.cmd_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_cmd_dir", 32'(bus.cmd_dir), 32'd0);
    check("rst_held", 32'(held_vec()), 32'd0);
    check("rst_pause", 32'(pause_pulse), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    n_checks = 0;
    n_pass   = 0;
    rst_n          = 1'b0;
    bus.uart_data  = 8'h00;
    bus.uart_valid = 1'b0;
    bus.cmd_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_reset();

    // 1: 'w' then 'D', no consumer
    send_byte(8'h77);
    check("t1_valid", 32'(bus.cmd_valid), 32'd1);
    check("t1_dir_up", 32'(bus.cmd_dir), 32'(DIR_UP));
    check("t1_held_up", 32'(held_vec()), 32'b1000);
    send_byte(8'h44);
    check("t1_head_still_up", 32'(bus.cmd_dir), 32'(DIR_UP));
    check("t1_held_right", 32'(held_vec()), 32'b0001);
    pop_one();
    check("t1_dir_right", 32'(bus.cmd_dir), 32'(DIR_RIGHT));
    pop_one();
    check("t1_empty", 32'(bus.cmd_valid), 32'd0);

    // 2: arrow sequences
    send_byte(8'h1B);
    check("t2_state_esc", 32'(dbg_state), 32'(ST_ESC));
    check("t2_no_push_esc", 32'(bus.cmd_valid), 32'd0);
    send_byte(8'h5B);
    check("t2_state_csi", 32'(dbg_state), 32'(ST_CSI));
    check("t2_no_push_csi", 32'(bus.cmd_valid), 32'd0);
    send_byte(8'h41);
    check("t2_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.push_back(DIR_UP);
    drain_expected("t2_arrow_a");
    send_byte(8'h1B);
    send_byte(8'h5B);
    send_byte(8'h44);
    exp_q.push_back(DIR_LEFT);
    drain_expected("t2_arrow_d");

    // 3: ESC fallback and timeout
    send_byte(8'h1B);
    send_byte(8'h73);
    check("t3_fallback_idle", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.push_back(DIR_DOWN);
    drain_expected("t3_esc_s");
    send_byte(8'h1B);
    repeat (ESC_TIMEOUT + 1) @(negedge clk);
    check("t3_timeout_idle", 32'(dbg_state), 32'(ST_IDLE));
    send_byte(8'h41);
    exp_q.push_back(DIR_LEFT);
    drain_expected("t3_after_timeout");

    // 4: overflow
    send_byte(8'h77); exp_q.push_back(DIR_UP);
    send_byte(8'h73); exp_q.push_back(DIR_DOWN);
    send_byte(8'h61); exp_q.push_back(DIR_LEFT);
    send_byte(8'h64); exp_q.push_back(DIR_RIGHT);
    check("t4_no_ovf_4th", 32'(overflow), 32'd0);
    send_byte(8'h57);
    check("t4_ovf_5th", 32'(overflow), 32'd1);
    @(negedge clk);
    check("t4_ovf_one_cycle", 32'(overflow), 32'd0);
    send_pop(8'h57);
    check("t4_no_ovf_with_pop", 32'(overflow), 32'd0);
    void'(exp_q.pop_front());
    exp_q.push_back(DIR_UP);
    drain_expected("t4_order");

    // 5: hold stretching
    repeat (HOLD_CYCLES + 2) @(negedge clk);
    check("t5_held_idle", 32'(held_vec()), 32'd0);
    send_byte(8'h61);
    check("t5_held_left", 32'(held_vec()), 32'b0010);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (held_left) hi++;
      else break;
    end
    check("t5_hold_len", 32'(hi), 32'd10);
    send_byte(8'h61);
    repeat (3) @(negedge clk);
    send_byte(8'h61);
    hi = 6;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (held_left) hi++;
      else break;
    end
    check("t5_hold_extended", 32'(hi), 32'd15);
    exp_q.push_back(DIR_LEFT);
    exp_q.push_back(DIR_LEFT);
    exp_q.push_back(DIR_LEFT);

    // 6: pause and reset mid-CSI
    send_byte(8'h70);
    check("t6_pause_hi", 32'(pause_pulse), 32'd1);
    check("t6_fifo_kept", 32'(bus.cmd_dir), 32'(DIR_LEFT));
    @(negedge clk);
    check("t6_pause_lo", 32'(pause_pulse), 32'd0);
    drain_expected("t6_after_pause");
    send_byte(8'h64);
    send_byte(8'h1B);
    send_byte(8'h5B);
    check("t6_in_csi", 32'(dbg_state), 32'(ST_CSI));
    do_reset();
    send_byte(8'h5B);
    check("t6_bracket_ignored", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_no_push", 32'(bus.cmd_valid), 32'd0);
    send_byte(8'h41);
    exp_q.push_back(DIR_LEFT);
    drain_expected("t6_plain_a");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
